sram_access_ctrl: RTL and testbench

//  Digital-to-analog access sequencer directly upstream of the SRAM row decoder.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_phase_timer.sv | 27 ++
 rtl/sram_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared levels, FSM state encoding and real/bit conversion helpers for the
// SRAM access sequencer.
package sram_pkg;

  parameter real VDD = 1.5;
  parameter real VSS = 0.0;
  parameter real VTH = 0.8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRE    = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic real to_real(input logic b);
    return b ? VDD : VSS;
  endfunction

  function automatic logic to_bit(input real v);
    return (v >= VTH);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing one sequencer phase; done_c flags the last
// cycle of the loaded interval.
module sram_phase_timer #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done_c
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: precharge -> wordline access -> response, driving
// real-valued decoder/rail levels. Define SRAM_STATS_EN for rd/wr/err counters.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter  int unsigned ROWS    = 16,
  parameter  int unsigned COLS    = 8,
  parameter  int unsigned PRE_CYC = 2,
  parameter  int unsigned WL_CYC  = 3,
  localparam int unsigned AW      = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_err,
  output logic [COLS-1:0] rsp_rdata,
  output real             row_sel [AW],
  output real             pre_en,
  output real             wl_en,
  output real             se_en,
  output real             bl_wr [COLS],
`ifdef SRAM_STATS_EN
  output logic [15:0]     rd_cnt,
  output logic [15:0]     wr_cnt,
  output logic [15:0]     err_cnt,
`endif
  input  real             bl_rd [COLS]
);

  localparam int unsigned MAXC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  state_t            state, state_nxt;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [COLS-1:0]   wdata_q;
  logic [COLS-1:0]   rd_bits_c;
  logic [AW-1:0]     code_c;
  logic              err_addr_c;
  logic              accept_c;
  logic              done_c;
  logic              load_c;
  logic [CW-1:0]     load_val_c;
  logic              rsp_hs_c;

  assign err_addr_c = (req_addr == AW'(ROWS - 1));
  assign accept_c   = (state == IDLE) && req_valid;
  assign rsp_hs_c   = (state == RESP) && rsp_ready;
  assign code_c     = AW'(addr_q + AW'(1));

  // Timer is reloaded on entry to PRE and on entry to ACCESS.
  assign load_c     = (accept_c && !err_addr_c) || ((state == PRE) && done_c);
  assign load_val_c = (state == IDLE) ? CW'(PRE_CYC - 1) : CW'(WL_CYC - 1);

  sram_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (load_val_c),
    .done_c   (done_c)
  );

  always_comb begin
    for (int i = 0; i < COLS; i++) rd_bits_c[i] = to_bit(bl_rd[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = err_addr_c ? RESP : PRE;
      PRE:     if (done_c)    state_nxt = ACCESS;
      ACCESS:  if (done_c)    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    pre_en    = VSS;
    wl_en     = VSS;
    se_en     = VSS;
    for (int i = 0; i < AW; i++)   row_sel[i] = VSS;
    for (int i = 0; i < COLS; i++) bl_wr[i]   = VSS;
    case (state)
      IDLE: req_ready = 1'b1;
      PRE:  pre_en    = VDD;
      ACCESS: begin
        wl_en = VDD;
        for (int i = 0; i < AW; i++) row_sel[i] = to_real(code_c[i]);
        if (we_q) begin
          for (int i = 0; i < COLS; i++) bl_wr[i] = to_real(wdata_q[i]);
        end else if (done_c) begin
          se_en = VDD;
        end
      end
      RESP:    rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Request latch and response registers; read data captured on the sense cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept_c) begin
        we_q      <= req_we;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        rsp_err   <= err_addr_c;
        rsp_rdata <= '0;
      end
      if ((state == ACCESS) && done_c && !we_q) begin
        rsp_rdata <= rd_bits_c;
      end
    end
  end

`ifdef SRAM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (rsp_hs_c) begin
      if (rsp_err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (we_q) begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end else begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_hs;
  assign unused_hs = rsp_hs_c;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: transaction-level model checked every
// cycle, plus directed literal checks of the documented scenarios.
module tb_sram_access_ctrl;

  localparam int unsigned ROWS    = 16;
  localparam int unsigned COLS    = 8;
  localparam int unsigned PRE_CYC = 2;
  localparam int unsigned WL_CYC  = 3;
  localparam int unsigned AW      = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_we, rsp_ready;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            req_ready, rsp_valid, rsp_err;
  logic [COLS-1:0] rsp_rdata;
  real             row_sel [AW];
  real             pre_en, wl_en, se_en;
  real             bl_wr [COLS];
  real             bl_rd [COLS];
`ifdef SRAM_STATS_EN
  logic [15:0]     rd_cnt, wr_cnt, err_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sram_access_ctrl #(.ROWS(ROWS), .COLS(COLS), .PRE_CYC(PRE_CYC), .WL_CYC(WL_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .row_sel   (row_sel),
    .pre_en    (pre_en),
    .wl_en     (wl_en),
    .se_en     (se_en),
    .bl_wr     (bl_wr),
`ifdef SRAM_STATS_EN
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .err_cnt   (err_cnt),
`endif
    .bl_rd     (bl_rd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_r(input string nm, input real act, input real exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %f expected %f at %0t", nm, act, exp, $time);
  endtask

  task automatic set_rd(input logic [COLS-1:0] v);
    for (int i = 0; i < COLS; i++) bl_rd[i] = v[i] ? 1.2 : 0.3;
  endtask

  // Present one request for one cycle; returns 2 time units after the accept edge.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [COLS-1:0] data);
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  // Transaction model: m_k is the 1-based cycle number since acceptance.
  bit              m_started = 0;
  bit              m_busy = 0;
  bit              m_err, m_we;
  int              m_k, m_rsp_at;
  logic [AW-1:0]   m_addr;
  logic [COLS-1:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_started = 1; m_busy = 0; m_err = 0; m_rdata = '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy   = 1;
        m_we     = req_we;
        m_addr   = req_addr;
        m_wdata  = req_wdata;
        m_err    = (int'(req_addr) == ROWS - 1);
        m_rsp_at = m_err ? 1 : PRE_CYC + WL_CYC + 1;
        m_rdata  = '0;
        m_k      = 1;
      end
    end else if (m_k >= m_rsp_at && rsp_ready) begin
      m_busy = 0;
    end else begin
      if (!m_we && !m_err && m_k == PRE_CYC + WL_CYC)
        for (int i = 0; i < COLS; i++) m_rdata[i] = (bl_rd[i] >= 0.8);
      m_k++;
    end
  end

  bit            e_pre, e_acc, e_resp;
  logic [AW-1:0] e_code;

  always @(negedge clk) begin
    if (m_started) begin
      e_resp = m_busy && m_k >= m_rsp_at;
      e_pre  = m_busy && !m_err && m_k >= 1 && m_k <= PRE_CYC;
      e_acc  = m_busy && !m_err && m_k > PRE_CYC && m_k <= PRE_CYC + WL_CYC;
      e_code = e_acc ? AW'(m_addr + 1) : '0;
      chk("m_req_ready", 32'(req_ready), 32'(!m_busy));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_resp));
      chk_r("m_pre_en", pre_en, e_pre ? 1.5 : 0.0);
      chk_r("m_wl_en", wl_en, e_acc ? 1.5 : 0.0);
      chk_r("m_se_en", se_en, (e_acc && !m_we && m_k == PRE_CYC + WL_CYC) ? 1.5 : 0.0);
      for (int i = 0; i < AW; i++)
        chk_r($sformatf("m_row_sel%0d", i), row_sel[i], e_code[i] ? 1.5 : 0.0);
      for (int i = 0; i < COLS; i++)
        chk_r($sformatf("m_bl_wr%0d", i), bl_wr[i], (e_acc && m_we && m_wdata[i]) ? 1.5 : 0.0);
      if (e_resp) begin
        chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
        chk("m_rsp_rdata", 32'(rsp_rdata), (m_err || m_we) ? 32'h0 : 32'(m_rdata));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    set_rd(8'h00);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk_r("rst_pre_en", pre_en, 0.0);
    chk_r("rst_wl_en", wl_en, 0.0);
    #1 rst_n = 1'b1;

    // Write addr 3, data A5
    do_req(1'b1, 4'd3, 8'hA5);
    @(negedge clk); chk_r("wr_pre_c1", pre_en, 1.5);
    @(negedge clk); chk_r("wr_pre_c2", pre_en, 1.5);
    @(negedge clk);
    chk_r("wr_c3_rs0", row_sel[0], 0.0);
    chk_r("wr_c3_rs2", row_sel[2], 1.5);
    chk_r("wr_c3_wl", wl_en, 1.5);
    chk_r("wr_c3_pre", pre_en, 0.0);
    chk_r("wr_c3_bl0", bl_wr[0], 1.5);
    chk_r("wr_c3_bl1", bl_wr[1], 0.0);
    repeat (2) @(negedge clk);
    chk_r("wr_c5_bl7", bl_wr[7], 1.5);
    @(negedge clk);
    chk("wr_c6_valid", 32'(rsp_valid), 32'h1);
    chk("wr_c6_rdata", 32'(rsp_rdata), 32'h0);
    chk("wr_c6_err", 32'(rsp_err), 32'h0);

    // Read addr 0 with sensed 3C
    set_rd(8'h3C);
    do_req(1'b0, 4'd0, 8'h00);
    repeat (4) @(negedge clk); chk_r("rd_c4_se", se_en, 0.0);
    @(negedge clk); chk_r("rd_c5_se", se_en, 1.5);
    @(negedge clk);
    chk("rd_c6_valid", 32'(rsp_valid), 32'h1);
    chk("rd_c6_rdata", 32'(rsp_rdata), 32'h3C);
    chk("rd_c6_err", 32'(rsp_err), 32'h0);

    // Illegal address
    do_req(1'b0, 4'd15, 8'h00);
    @(negedge clk);
    chk("err_c1_valid", 32'(rsp_valid), 32'h1);
    chk("err_c1_err", 32'(rsp_err), 32'h1);
    chk("err_c1_rdata", 32'(rsp_rdata), 32'h0);
    chk_r("err_c1_pre", pre_en, 0.0);

    // Response backpressure
    set_rd(8'h81);
    do_req(1'b0, 4'd5, 8'h00);
    rsp_ready = 1'b0;
    repeat (5) @(negedge clk);
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("bp_c%0d_valid", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_c%0d_rdata", c), 32'(rsp_rdata), 32'h81);
      chk($sformatf("bp_c%0d_ready", c), 32'(req_ready), 32'h0);
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    do_req(1'b1, 4'd14, 8'h0F);
    repeat (3) @(negedge clk);
    chk_r("hi_c3_rs3", row_sel[3], 1.5);
    chk_r("hi_c3_rs0", row_sel[0], 1.5);
    repeat (3) @(negedge clk);
    chk("hi_c6_valid", 32'(rsp_valid), 32'h1);
`ifdef SRAM_STATS_EN
    @(posedge clk); #1;
    chk("st_rd", 32'(rd_cnt), 32'd2);
    chk("st_wr", 32'(wr_cnt), 32'd2);
    chk("st_err", 32'(err_cnt), 32'd1);
`endif

    // Reset during ACCESS
    do_req(1'b1, 4'd2, 8'hFF);
    repeat (3) @(negedge clk);
    chk_r("ab_c3_wl", wl_en, 1.5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_r("ab_wl", wl_en, 0.0);
    chk_r("ab_bl0", bl_wr[0], 0.0);
    chk_r("ab_rs0", row_sel[0], 0.0);
    chk("ab_valid", 32'(rsp_valid), 32'h0);
    chk("ab_ready", 32'(req_ready), 32'h1);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("ab_late_valid", 32'(rsp_valid), 32'h0);
`ifdef SRAM_STATS_EN
    chk("st_ab_wr", 32'(wr_cnt), 32'd0);
`endif

    // Recovery read
    set_rd(8'h5A);
    do_req(1'b0, 4'd1, 8'h00);
    repeat (6) @(negedge clk);
    chk("rc_c6_rdata", 32'(rsp_rdata), 32'h5A);
`ifdef SRAM_STATS_EN
    @(posedge clk); #1;
    chk("st_rc_rd", 32'(rd_cnt), 32'd1);
`endif
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
